// File: rtl/clock_gen_pkg.sv
// clock_gen_pkg: shared state codes and width defaults for the fractional clock generator.
package clock_gen_pkg;
    localparam int FREQ_W_DEF = 32;
    localparam int INIT_W_DEF = 9;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_ERROR = 3'd3,
        ST_STOP  = 3'd4
    } state_t;
endpackage

// File: rtl/clock_gen_chan.sv
// clock_gen_chan: one channel of the Bresenham clock divider with start-up delay and glitch-free stop.
module clock_gen_chan
    import clock_gen_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int INIT_W = INIT_W_DEF
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic [FREQ_W-1:0] ref_count,
    input  logic [FREQ_W-1:0] target,
    input  logic [INIT_W-1:0] init,
    input  logic              enable,
    input  logic              load,
    output logic              out,
    output logic [2:0]        status
);
    state_t            state, state_n, load_state;
    logic [FREQ_W-1:0] ref_r, ref_n, tgt_r, tgt_n, acc, acc_n, acc_step;
    logic [INIT_W-1:0] cnt, cnt_n;
    logic [FREQ_W:0]   sum;
    logic              out_n, cfg_ok, reload, wrap;

    assign cfg_ok     = (ref_count != '0) && (target != '0) && ({target, 1'b0} <= {1'b0, ref_count});
    assign reload     = load && enable;
    assign load_state = !cfg_ok ? ST_ERROR : (init == '0 ? ST_RUN : ST_WAIT);
    // acc < ref always, so the wrapped remainder fits in FREQ_W bits
    assign sum        = {1'b0, acc} + {tgt_r, 1'b0};
    assign wrap       = sum >= {1'b0, ref_r};
    assign acc_step   = wrap ? sum[FREQ_W-1:0] - ref_r : sum[FREQ_W-1:0];
    assign status     = state;

    always_comb begin
        state_n = state;
        ref_n   = ref_r;
        tgt_n   = tgt_r;
        acc_n   = acc;
        cnt_n   = cnt;
        out_n   = out;
        if (reload) begin
            state_n = load_state;
            ref_n   = ref_count;
            tgt_n   = target;
            acc_n   = '0;
            cnt_n   = init;
            out_n   = cfg_ok && out;
        end else begin
            case (state)
                ST_WAIT: begin
                    cnt_n = cnt - 1'b1;
                    if (!enable)
                        state_n = out ? ST_STOP : ST_IDLE;
                    else if (cnt <= INIT_W'(1))
                        state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (!enable && !out) begin
                        state_n = ST_IDLE;
                    end else begin
                        acc_n = acc_step;
                        out_n = out ^ wrap;
                        // a high phase in progress finishes in STOP so no runt pulse appears
                        if (!enable)
                            state_n = wrap ? ST_IDLE : ST_STOP;
                    end
                end
                ST_STOP: begin
                    acc_n = acc_step;
                    if (wrap) begin
                        out_n   = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
                ST_ERROR: state_n = enable ? ST_ERROR : ST_IDLE;
                ST_IDLE:  state_n = ST_IDLE;
                default: begin
                    state_n = ST_IDLE;
                    out_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ref_r <= '0;
            tgt_r <= '0;
            acc   <= '0;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_n;
            ref_r <= ref_n;
            tgt_r <= tgt_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            out   <= out_n;
        end
    end
endmodule

// File: rtl/clock_gen_multi.sv
// clock_gen_multi: CHANNELS independent fractional clock generators sharing one reference word.
module clock_gen_multi
    import clock_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int INIT_W   = INIT_W_DEF
) (
    input  logic                       ref_clk,
    input  logic                       reset,
    input  logic [FREQ_W-1:0]          ref_count,
    input  logic [CHANNELS*FREQ_W-1:0] target,
    input  logic [CHANNELS*INIT_W-1:0] init,
    input  logic [CHANNELS-1:0]        enable,
    input  logic                       load,
    output logic [CHANNELS-1:0]        out,
    output logic [CHANNELS*3-1:0]      status
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clock_gen_chan #(
            .FREQ_W(FREQ_W),
            .INIT_W(INIT_W)
        ) u_chan (
            .ref_clk  (ref_clk),
            .reset    (reset),
            .ref_count(ref_count),
            .target   (target[i*FREQ_W +: FREQ_W]),
            .init     (init[i*INIT_W +: INIT_W]),
            .enable   (enable[i]),
            .load     (load),
            .out      (out[i]),
            .status   (status[3*i +: 3])
        );
    end
endmodule

// File: doc/clock_gen_multi.md
# clock_gen_multi

Multi-channel fractional clock generator, the parametrised successor to the single-channel CLOCK block. Each of `CHANNELS` outputs is a square wave at `target/ref` times the `ref_clk` frequency. The block uses an error-accumulator (Bresenham) divider with a programmable start-up delay, glitch-free start/stop and a per-channel 3-bit status. It sits next to the reference clock and feeds clock-enable or low-rate clock consumers.

## Interface
- `CHANNELS`, 4: number of independent output channels.
- `FREQ_W`, 32: width of the reference and target frequency words.
- `INIT_W`, 9: width of the per-channel start-up delay.

- `ref_clk`, in, 1: the only clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `ref_count`, in, `FREQ_W`: reference frequency word shared by all channels; latched per channel on load.
- `target`, in, `CHANNELS*FREQ_W`: per-channel target frequency word; channel i is at `[i*FREQ_W +: FREQ_W]`.
- `init`, in, `CHANNELS*INIT_W`: per-channel start-up delay in `ref_clk` cycles.
- `enable`, in, `CHANNELS`: per-channel run request (level).
- `load`, in, 1: single-cycle pulse; every channel with `enable[i]=1` latches `ref_count`, `target[i]` and `init[i]`.
- `out`, out, `CHANNELS`: registered square-wave outputs.
- `status`, out, `CHANNELS*3`: per-channel state code; channel i is at `[3*i +: 3]`.

## Operation
- **Per-channel state** (also the status code): IDLE=0, WAIT=1, RUN=2, ERROR=3, STOP=4. Codes 5–7 are unused and never produced.
- **Reset:** every channel is IDLE, `acc`=0, `cnt`=0, `out`=0, `status`=0.
- **Config valid** when `ref_count` != 0, `target` != 0, and `2*target <= ref_count`, computed at `FREQ_W+1` bits.
- **IDLE:** `out`=0.
  - `load` with `enable[i]` and invalid config → ERROR.
  - `load` with `enable[i]` and valid config and `init`=0 → RUN.
  - `load` with `enable[i]` and valid config and `init`≠0 → WAIT with `cnt`=`init`.
  - `acc` is cleared on every load.
- **WAIT:** `cnt` decrements each cycle; at `cnt`==1 → RUN. `out` holds its current value.
- **RUN:** each cycle `sum = acc + 2*target`, computed at `FREQ_W+1` bits.
  - If `sum >= ref`: `acc <= sum - ref` and `out` toggles.
  - Otherwise `acc <= sum`.
  - `acc` stays below `ref` at all times.
- **Enable dropped in RUN:**
  - If `out`=0 → IDLE next cycle.
  - If `out`=1 → STOP.
- **STOP:** keeps accumulating. On the toggle that drives `out` to 0 → IDLE. No runt high pulse is ever produced.
  - `enable[i]` re-asserted with `load` while in STOP → treated as a reload (next bullet).
- **Reload:** `load` with `enable[i]` in WAIT, RUN or STOP re-latches the config, clears `acc`, holds the `out` level, and re-enters WAIT, RUN or ERROR by the IDLE rules above.
- **ERROR:** `out`=0.
  - Leaves only on `load` with a valid config (→ WAIT/RUN), or on `enable[i]`=0 (→ IDLE).
- **Precedence:** `load` wins over `enable` falling only if `enable[i]`=1 in the same cycle. `load` with `enable[i]`=0 is ignored for channel i.
- **Independence:** channels never interact; each latches its own copy of `ref_count`.

## Timing
- All outputs are registered. `status` reflects the state one cycle after the causing edge.
- `load` at cycle 0 with `init`=N>0: WAIT at cycles 1..N, first RUN cycle at N+1.
- `load` at cycle 0 with `init`=0: RUN at cycle 1.
- The first toggle appears on the edge ending the k-th RUN cycle, where k = ceil(ref/(2*target)).
- Output period averages `ref/target` cycles. The high/low lengths are each `floor` or `ceil` of `ref/(2*target)`.
- `2*target == ref` gives toggling every cycle, i.e. `ref_clk/2`.
- Asynchronous `reset` mid-operation forces IDLE and `out`=0 immediately, with no completion of the current half-period.

## Structure
- Package `clock_gen_pkg`: 3-bit state localparams (IDLE, WAIT, RUN, ERROR, STOP) and the `FREQ_W`/`INIT_W` defaults.
- Sub-module `clock_gen_chan`: one channel's FSM, accumulator and counter.
- The top level is a generate loop over `CHANNELS` plus port slicing.

## Test plan
- **Basic divide:** `ref`=10, `target`=2, `init`=0, load on ch0.
  - `out` rises at RUN cycles 3, 8, 13 and falls at 5, 10.
  - Period is 5 cycles; `status`=2.
- **Start-up delay:** `init`=20, `ref`=10, `target`=1.
  - `status`=1 for 20 cycles, then 2.
  - First rise 5 cycles after entering RUN; period 10.
- **Invalid config:** `ref`=10, `target`=8000 (and separately `target`=0).
  - `status`=3, `out` stuck at 0.
  - A valid reload leaves ERROR.
- **Glitch-free stop:** drop `enable` while `out`=1 with `ref`=10, `target`=1.
  - `status`=4 until the falling toggle, then 0.
  - High phase is exactly 5 cycles.
- **Maximum rate:** `ref`=6, `target`=3.
  - `out` toggles every RUN cycle.
- **Multi-channel and reset:** ch0..3 run with targets 1, 2, 3, 5 of `ref`=10.
  - Outputs are independent with periods 10, 5, 3.33 (mixed 3/4), 2.
  - Asserting `reset` mid-run zeroes all `out` and `status` immediately.
